// File: rtl/rf_wb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package rf_wb_pkg;

  localparam int XLEN_DEFAULT         = 32;
  localparam int REG_AW               = 5;
  localparam int STARVE_LIMIT_DEFAULT = 2;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2
  } wb_src_e;

  // x0 is hardwired to zero, so a write to it is a discarded write.
  function automatic logic is_real_write(input logic [REG_AW-1:0] rd);
    return (rd != {REG_AW{1'b0}});
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry result buffer with valid/ready input and an external grant
// that drains it; a same-edge refill keeps one write per cycle flowing.
module wb_slot
  import rf_wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [XLEN-1:0]   in_data,
  output logic              in_ready,
  input  logic              grant,
  output logic              full,
  output logic [REG_AW-1:0] rd,
  output logic [XLEN-1:0]   data
);

  logic              full_r;
  logic [REG_AW-1:0] rd_r;
  logic [XLEN-1:0]   data_r;
  logic              push_s;

  assign in_ready = !full_r || grant;
  assign push_s   = in_valid && in_ready;
  assign full     = full_r;
  assign rd       = rd_r;
  assign data     = data_r;

  // Slot state: reset clears, push loads, grant without refill empties.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_r <= 1'b0;
      rd_r   <= {REG_AW{1'b0}};
      data_r <= {XLEN{1'b0}};
    end else if (push_s) begin
      full_r <= 1'b1;
      rd_r   <= in_rd;
      data_r <= in_data;
    end else if (grant) begin
      full_r <= 1'b0;
      rd_r   <= rd_r;
      data_r <= data_r;
    end else begin
      full_r <= full_r;
      rd_r   <= rd_r;
      data_r <= data_r;
    end
  end

endmodule

// File: rtl/rf_writeback.sv
// Writeback arbiter: ALU and LSU result slots share one register-file write
// port, LSU first unless the ALU has starved. Optional read bypass under
// macro RF_WRITEBACK_BYPASS_EN.
module rf_writeback
  import rf_wb_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              lsu_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  output logic [XLEN-1:0]   fwd_rdata1,
  output logic [XLEN-1:0]   fwd_rdata2
);

  logic              alu_full_s, lsu_full_s;
  logic [REG_AW-1:0] alu_slot_rd_s, lsu_slot_rd_s;
  logic [XLEN-1:0]   alu_slot_data_s, lsu_slot_data_s;
  logic              alu_grant_s, lsu_grant_s, starve_s;
  logic [1:0]        alu_wait_r;
  wb_src_e           src_s;
  logic [REG_AW-1:0] sel_rd_s;
  logic [XLEN-1:0]   sel_data_s;

  wb_slot #(.XLEN(XLEN)) u_alu_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (alu_valid),
    .in_rd    (alu_rd),
    .in_data  (alu_data),
    .in_ready (alu_ready),
    .grant    (alu_grant_s),
    .full     (alu_full_s),
    .rd       (alu_slot_rd_s),
    .data     (alu_slot_data_s)
  );

  wb_slot #(.XLEN(XLEN)) u_lsu_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (lsu_valid),
    .in_rd    (lsu_rd),
    .in_data  (lsu_data),
    .in_ready (lsu_ready),
    .grant    (lsu_grant_s),
    .full     (lsu_full_s),
    .rd       (lsu_slot_rd_s),
    .data     (lsu_slot_data_s)
  );

  // Grant depends only on slot state, so ready never loops back through inputs.
  assign starve_s    = (32'(alu_wait_r) >= 32'(STARVE_LIMIT));
  assign alu_grant_s = alu_full_s && (!lsu_full_s || starve_s);
  assign lsu_grant_s = lsu_full_s && !alu_grant_s;

  // Starvation counter: saturates at 3, clears on ALU grant or empty slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_wait_r <= 2'd0;
    end else if (!alu_full_s || alu_grant_s) begin
      alu_wait_r <= 2'd0;
    end else if (alu_wait_r != 2'd3) begin
      alu_wait_r <= alu_wait_r + 2'd1;
    end else begin
      alu_wait_r <= alu_wait_r;
    end
  end

  // Encode which slot owns the write port this cycle.
  always_comb begin
    src_s = SRC_NONE;
    if (alu_grant_s) begin
      src_s = SRC_ALU;
    end else if (lsu_grant_s) begin
      src_s = SRC_LSU;
    end else begin
      src_s = SRC_NONE;
    end
  end

  // Drive the write port from the granted slot; all-zero when not writing.
  always_comb begin
    sel_rd_s   = {REG_AW{1'b0}};
    sel_data_s = {XLEN{1'b0}};
    rf_we      = 1'b0;
    rf_waddr   = {REG_AW{1'b0}};
    rf_wdata   = {XLEN{1'b0}};
    case (src_s)
      SRC_ALU: begin
        sel_rd_s   = alu_slot_rd_s;
        sel_data_s = alu_slot_data_s;
      end
      SRC_LSU: begin
        sel_rd_s   = lsu_slot_rd_s;
        sel_data_s = lsu_slot_data_s;
      end
      default: begin
        sel_rd_s   = {REG_AW{1'b0}};
        sel_data_s = {XLEN{1'b0}};
      end
    endcase
    if ((src_s != SRC_NONE) && is_real_write(sel_rd_s)) begin
      rf_we    = 1'b1;
      rf_waddr = sel_rd_s;
      rf_wdata = sel_data_s;
    end else begin
      rf_we    = 1'b0;
      rf_waddr = {REG_AW{1'b0}};
      rf_wdata = {XLEN{1'b0}};
    end
  end

`ifdef RF_WRITEBACK_BYPASS_EN
  // Forward the in-flight write to a matching read port (never for x0).
  always_comb begin
    fwd_rdata1 = rf_rdata1;
    fwd_rdata2 = rf_rdata2;
    if (rf_we && (rf_waddr == raddr1) && is_real_write(raddr1)) begin
      fwd_rdata1 = rf_wdata;
    end else begin
      fwd_rdata1 = rf_rdata1;
    end
    if (rf_we && (rf_waddr == raddr2) && is_real_write(raddr2)) begin
      fwd_rdata2 = rf_wdata;
    end else begin
      fwd_rdata2 = rf_rdata2;
    end
  end
`else
  logic unused_raddr;
  assign unused_raddr = ^{raddr1, raddr2};
  assign fwd_rdata1   = rf_rdata1;
  assign fwd_rdata2   = rf_rdata2;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Directed, table-driven bench for rf_writeback plus hand-written
// streaming and starvation sequences.
module tb_rf_writeback;

`ifdef RF_WRITEBACK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid, alu_ready, lsu_ready, rf_we;
  logic [4:0]  alu_rd, lsu_rd, rf_waddr, raddr1, raddr2;
  logic [31:0] alu_data, lsu_data, rf_wdata, rf_rdata1, rf_rdata2;
  logic [31:0] fwd_rdata1, fwd_rdata2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  rf_writeback dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .lsu_valid  (lsu_valid),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .lsu_ready  (lsu_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .fwd_rdata1 (fwd_rdata1),
    .fwd_rdata2 (fwd_rdata2)
  );

  typedef struct {
    logic        rst_n;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic [4:0]  ra1;
    logic [31:0] rd1;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ar;
    logic        lr;
    logic [31:0] f1;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    int found;
    //           rst   av    ard    adat          lv    lrd    ldat          ra1    rd1             we    wa     wd            ar    lr    f1
    vecs[0]  = '{1'b0, 1'b1, 5'd1,  32'h1,        1'b1, 5'd2,  32'h2,        5'd0,  32'h1111, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 32'h1111};
    vecs[1]  = '{1'b0, 1'b1, 5'd1,  32'h1,        1'b1, 5'd2,  32'h2,        5'd0,  32'h1111, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 32'h1111};
    vecs[2]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  32'h1111, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 32'h1111};
    // single source back-to-back
    vecs[3]  = '{1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd0,  32'h1111, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 32'h1111};
    vecs[4]  = '{1'b1, 1'b1, 5'd6,  32'h1,        1'b0, 5'd0,  32'h0,        5'd5,  32'h1111, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b1, BYP ? 32'hDEADBEEF : 32'h1111};
    vecs[5]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  32'h1111, 1'b1, 5'd6,  32'h1,        1'b1, 1'b1, 32'h1111};
    vecs[6]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  32'h1111, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 32'h1111};
    // contention: ALU holds rd7, LSU streams rd3
    vecs[7]  = '{1'b1, 1'b1, 5'd7,  32'h77,       1'b1, 5'd3,  32'h30,       5'd0,  32'h1111, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 32'h1111};
    vecs[8]  = '{1'b1, 1'b1, 5'd7,  32'h77,       1'b1, 5'd3,  32'h31,       5'd0,  32'h1111, 1'b1, 5'd3,  32'h30,       1'b0, 1'b1, 32'h1111};
    vecs[9]  = '{1'b1, 1'b1, 5'd7,  32'h77,       1'b1, 5'd3,  32'h32,       5'd0,  32'h1111, 1'b1, 5'd3,  32'h31,       1'b0, 1'b1, 32'h1111};
    vecs[10] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h33,       5'd0,  32'h1111, 1'b1, 5'd7,  32'h77,       1'b1, 1'b0, 32'h1111};
    vecs[11] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  32'h1111, 1'b1, 5'd3,  32'h32,       1'b1, 1'b1, 32'h1111};
    // x0 discard
    vecs[12] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h55,       5'd0,  32'h1111, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 32'h1111};
    vecs[13] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  32'h1111, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 32'h1111};
    vecs[14] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  32'h1111, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 32'h1111};
    // same rd from both channels
    vecs[15] = '{1'b1, 1'b1, 5'd9,  32'hA,        1'b1, 5'd9,  32'hB,        5'd0,  32'h1111, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 32'h1111};
    vecs[16] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd9,  32'h1111, 1'b1, 5'd9,  32'hB,        1'b0, 1'b1, BYP ? 32'hB : 32'h1111};
    vecs[17] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  32'h2222, 1'b1, 5'd9,  32'hA,        1'b1, 1'b1, 32'h2222};
    // bypass
    vecs[18] = '{1'b1, 1'b1, 5'd9,  32'h1234,     1'b0, 5'd0,  32'h0,        5'd9,  32'h3333, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 32'h3333};
    vecs[19] = '{1'b1, 1'b1, 5'd0,  32'h9999,     1'b0, 5'd0,  32'h0,        5'd9,  32'h4444, 1'b1, 5'd9,  32'h1234,     1'b1, 1'b1, BYP ? 32'h1234 : 32'h4444};
    vecs[20] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  32'h5555, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 32'h5555};
    // reset mid-operation discards held entries
    vecs[21] = '{1'b1, 1'b1, 5'd10, 32'hAA,       1'b1, 5'd11, 32'hBB,       5'd0,  32'h1111, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 32'h1111};
    vecs[22] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  32'h1111, 1'b1, 5'd11, 32'hBB,       1'b0, 1'b1, 32'h1111};
    vecs[23] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  32'h1111, 1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 32'h1111};

    rst_n = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
    alu_rd = 5'd0; lsu_rd = 5'd0; alu_data = 32'h0; lsu_data = 32'h0;
    raddr1 = 5'd0; raddr2 = 5'd0; rf_rdata1 = 32'h0; rf_rdata2 = 32'h0;
    @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adat;
      lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ldat;
      raddr1 = vecs[i].ra1; rf_rdata1 = vecs[i].rd1;
      #1;
      check($sformatf("v%0d_we", i),    {31'd0, rf_we},     {31'd0, vecs[i].we});
      check($sformatf("v%0d_waddr", i), {27'd0, rf_waddr},  {27'd0, vecs[i].wa});
      check($sformatf("v%0d_wdata", i), rf_wdata,           vecs[i].wd);
      check($sformatf("v%0d_aready", i),{31'd0, alu_ready}, {31'd0, vecs[i].ar});
      check($sformatf("v%0d_lready", i),{31'd0, lsu_ready}, {31'd0, vecs[i].lr});
      check($sformatf("v%0d_fwd1", i),  fwd_rdata1,         vecs[i].f1);
    end

    // LSU alone streams rd1..rd4 at one write per cycle
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      lsu_valid = (k < 4);
      lsu_rd    = 5'(k + 1);
      lsu_data  = 32'(100 + k);
      raddr2    = 5'd2;
      rf_rdata2 = 32'hF00D;
      #1;
      if (k == 0) begin
        check("stream_we0", {31'd0, rf_we}, 32'd0);
      end else begin
        check($sformatf("stream_we%0d", k),    {31'd0, rf_we},     32'd1);
        check($sformatf("stream_waddr%0d", k), {27'd0, rf_waddr},  32'(k));
        check($sformatf("stream_wdata%0d", k), rf_wdata,           32'(100 + k - 1));
      end
      check($sformatf("stream_lready%0d", k), {31'd0, lsu_ready}, 32'd1);
      if (k == 2) begin
        check("stream_fwd2", fwd_rdata2, BYP ? 32'd101 : 32'hF00D);
      end
    end

    // starvation: ALU holds rd12 while LSU streams rd13, bounded wait
    @(negedge clk);
    lsu_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC0;
    lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_data = 32'd200;
    found = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      alu_valid = 1'b0;
      lsu_data  = 32'(200 + n);
      #1;
      if (found == 0 && rf_we && rf_waddr == 5'd12) begin
        found = n;
        check("starve_wdata", rf_wdata, 32'hC0);
      end
    end
    check("starve_grant_cycle", 32'(found), 32'd3);

    @(negedge clk);
    lsu_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("drain_we", {31'd0, rf_we}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
